// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of async_fifo among
// NUM_REQ producers in the write-clock domain. One producer owns the port at a
// time for a burst of at most BURST_MAX accepted words. Its data is muxed onto
// the FIFO write port, and the arbiter stalls on `full` without dropping words.
//
// Parameters:
//   NUM_REQ   - number of producers (2..8)
//   WIDTH     - data word width, matches the FIFO
//   BURST_MAX - maximum accepted words per grant (1..15)
//
// Ports:
//   clk       in   write-domain clock (FIFO wr_clk)
//   rst       in   asynchronous active-high reset
//   req       in   per-producer level request, held while data is pending
//   wdata_in  in   producer data, producer i on [i*WIDTH +: WIDTH]
//   full      in   FIFO full flag
//   gnt       out  registered one-hot grant, all-zero when idle
//   ack       out  word accepted at the coming edge (gnt & req & ~full)
//   wr_en     out  FIFO write enable (|ack)
//   wdata     out  owner's data slice, 0 when no grant
//   stall_cnt out  cycles the owner was blocked by full (saturating)
//
// Optional feature macro: FIFO_WR_ARB_STATS_EN
//   defined   -> stall_cnt counts full-stall cycles
//   undefined -> stall_cnt is tied to 16'h0000
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] wdata_in,
    input  logic                     full,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wdata,
    output logic [15:0]              stall_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [3:0]       burst;

    logic             owner_req;
    logic             owner_ack;
    logic             burst_done;
    logic             release_now;
    logic [IDX_W-1:0] pick_base;
    logic [IDX_W:0]   pick_res;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    // Round-robin search: first set request strictly after `after`, wrapping
    // around so that `after` itself is considered last. Returns {found, idx}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   after);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(after) + k) % NUM_REQ;
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
        return {found, idx};
    endfunction

    // Write-port side: purely combinational from registered gnt, live req
    // and full. gnt is cleared asynchronously, so these read 0 during reset.
    assign ack   = gnt & req & {NUM_REQ{~full}};
    assign wr_en = |ack;

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                wdata = wdata | wdata_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // gnt is one-hot, so masking avoids indexing by owner.
    assign owner_req   = |(gnt & req);
    assign owner_ack   = |ack;
    assign burst_done  = owner_ack && (burst == 4'(BURST_MAX - 1));
    assign release_now = (state == S_GRANT) && (!owner_req || burst_done);

    // From IDLE search after the previous owner; on release search after the
    // current owner, so it re-wins only when nobody else is requesting.
    assign pick_base  = (state == S_IDLE) ? last : owner;
    assign pick_res   = rr_pick(req, pick_base);
    assign pick_found = pick_res[IDX_W];
    assign pick_idx   = pick_res[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            gnt   <= '0;
            last  <= IDX_W'(NUM_REQ - 1);
            owner <= '0;
            burst <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state <= S_GRANT;
                        gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner <= pick_idx;
                        burst <= '0;
                    end
                end
                S_GRANT: begin
                    if (release_now) begin
                        last  <= owner;
                        burst <= '0;
                        if (pick_found) begin
                            gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                            owner <= pick_idx;
                        end else begin
                            state <= S_IDLE;
                            gnt   <= '0;
                        end
                    end else if (owner_ack) begin
                        burst <= burst + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_q;

    // Counts only cycles where the owner actually has a word blocked by full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else if (owner_req && full && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Producer models hold queued words and follow the request/ack contract.
// Directed tests push the hand-ordered expected FIFO writes into a
// scoreboard. A negedge monitor pops and compares every accepted word.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BM = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata_in;
    logic           full;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           wr_en;
    logic [W-1:0]   wdata;
    logic [15:0]    stall_cnt;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .BURST_MAX(BM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wdata_in  (wdata_in),
        .full      (full),
        .gnt       (gnt),
        .ack       (ack),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // producer word stores
    logic [7:0] pm [N][16];
    int         rd [N];
    int         cnt[N];
    logic [N-1:0] ack_neg = '0;

    // scoreboard: {producer id, data}
    logic [15:0] exp_q[$];

`ifdef FIFO_WR_ARB_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd5;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_prod();
        for (int i = 0; i < N; i++) begin
            req[i] = (rd[i] < cnt[i]);
            wdata_in[i*W +: W] = (rd[i] < cnt[i]) ? pm[i][rd[i]] : 8'h00;
        end
    endtask

    task automatic clear_prod();
        for (int i = 0; i < N; i++) begin
            rd[i]  = 0;
            cnt[i] = 0;
        end
        apply_prod();
    endtask

    task automatic load(input int id, input logic [7:0] d);
        pm[id][cnt[id]] = d;
        cnt[id] = cnt[id] + 1;
    endtask

    task automatic expect_w(input int id, input logic [7:0] d);
        exp_q.push_back({8'(id), d});
    endtask

    // advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        full = 1'b0;
        clear_prod();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int  left;
        bit  busy;
        left = 60;
        busy = 1'b1;
        while (busy && left > 0) begin
            busy = (gnt != '0) || (exp_q.size() != 0);
            for (int i = 0; i < N; i++) if (rd[i] < cnt[i]) busy = 1'b1;
            if (busy) begin
                tick();
                left--;
            end
        end
        check({name, "_idle_gnt"}, 32'(gnt), 32'h0);
        check({name, "_idle_wdata"}, 32'(wdata), 32'h0);
        check({name, "_sb_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    // producers: advance past acked word shortly after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ack_neg[i] && rd[i] < cnt[i]) rd[i] = rd[i] + 1;
            end
            apply_prod();
        end
    end

    // monitor / scoreboard checker
    initial begin
        logic [15:0] e;
        logic [3:0]  oh;
        forever begin
            @(negedge clk);
            ack_neg = ack;
            if (!rst) begin
                if (full) check("no_wr_when_full", 32'(wr_en), 32'h0);
                if (wr_en) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_write: got data %0h ack %b expected none", wdata, ack);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = 4'b0001 << e[9:8];
                        check("wr_ack", 32'(ack), 32'(oh));
                        check("wr_data", 32'(wdata), 32'(e[7:0]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[5];
        seq = '{0, 1, 2, 3, 0};
        req = '0;
        wdata_in = '0;
        full = 1'b0;
        clear_prod();

        // ---- test 1: single producer, 6 words, burst rollover ----
        rst = 1'b1;
        tick();
        for (int j = 0; j < 6; j++) begin
            load(0, 8'h11 + 8'(j));
            expect_w(0, 8'h11 + 8'(j));
        end
        apply_prod();
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wdata", 32'(wdata), 32'h0);
        check("rst_stall", 32'(stall_cnt), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t1_first_gnt", 32'(gnt), 32'h1);
        for (int k = 0; k < 6; k++) begin
            check("t1_wr_en", 32'(wr_en), 32'h1);
            check("t1_gnt", 32'(gnt), 32'h1);
            tick();
        end
        wait_idle("t1");
        check("t1_wr_en_idle", 32'(wr_en), 32'h0);

        // ---- test 2: all four continuous, order 0,1,2,3,0 ----
        do_reset();
        for (int j = 0; j < 8; j++) load(0, 8'h01 + 8'(j));
        for (int i = 1; i < N; i++)
            for (int j = 0; j < 4; j++) load(i, 8'(i * 32) + 8'h01 + 8'(j));
        for (int j = 0; j < 4; j++) expect_w(0, 8'h01 + 8'(j));
        for (int i = 1; i < N; i++)
            for (int j = 0; j < 4; j++) expect_w(i, 8'(i * 32) + 8'h01 + 8'(j));
        for (int j = 4; j < 8; j++) expect_w(0, 8'h01 + 8'(j));
        apply_prod();
        tick();
        for (int k = 0; k < 20; k++) begin
            check("t2_gnt_order", 32'(gnt), 32'(4'b0001 << seq[k / 4]));
            check("t2_wr_en", 32'(wr_en), 32'h1);
            tick();
        end
        wait_idle("t2");

        // ---- test 3: full stall mid-burst on owner 2 ----
        do_reset();
        for (int j = 0; j < 4; j++) begin
            load(2, 8'h81 + 8'(j));
            expect_w(2, 8'h81 + 8'(j));
        end
        apply_prod();
        tick();
        check("t3_gnt", 32'(gnt), 32'h4);
        tick();
        tick();
        full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t3_stall_wr_en", 32'(wr_en), 32'h0);
            check("t3_stall_gnt", 32'(gnt), 32'h4);
            tick();
        end
        full = 1'b0;
        #1;
        check("t3_stall_cnt", 32'(stall_cnt), 32'(EXP_STALL));
        check("t3_resume_wr_en", 32'(wr_en), 32'h1);
        check("t3_resume_word", 32'(wdata), 32'h83);
        wait_idle("t3");
        check("t3_stall_cnt_hold", 32'(stall_cnt), 32'(EXP_STALL));

        // ---- test 4: owner 1 drops req, handover to 3, then idle ----
        do_reset();
        load(1, 8'hA1); load(1, 8'hA2);
        load(3, 8'hC1); load(3, 8'hC2);
        expect_w(1, 8'hA1); expect_w(1, 8'hA2);
        expect_w(3, 8'hC1); expect_w(3, 8'hC2);
        apply_prod();
        tick();
        check("t4_gnt1", 32'(gnt), 32'h2);
        tick();
        tick();
        check("t4_gnt1_hold", 32'(gnt), 32'h2);
        check("t4_no_wr", 32'(wr_en), 32'h0);
        tick();
        check("t4_gnt3", 32'(gnt), 32'h8);
        wait_idle("t4");
        check("t4_idle_wr_en", 32'(wr_en), 32'h0);

        // ---- test 5: reset mid-burst, then producer 0 first ----
        do_reset();
        for (int j = 0; j < 4; j++) load(3, 8'hE1 + 8'(j));
        expect_w(3, 8'hE1);
        expect_w(3, 8'hE2);
        apply_prod();
        tick();
        check("t5_gnt3", 32'(gnt), 32'h8);
        tick();
        tick();
        check("t5_pre_rst_wr", 32'(wr_en), 32'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        check("t5_rst_wr_en", 32'(wr_en), 32'h0);
        check("t5_rst_wdata", 32'(wdata), 32'h0);
        clear_prod();
        load(0, 8'hF0);
        load(3, 8'hF3);
        expect_w(0, 8'hF0);
        expect_w(3, 8'hF3);
        apply_prod();
        tick();
        rst = 1'b0;
        tick();
        check("t5_gnt0_first", 32'(gnt), 32'h1);
        wait_idle("t5");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of `async_fifo` among `NUM_REQ` producers in the write-clock domain. Each producer requests, the arbiter grants one owner at a time for a bounded burst, muxes its data onto the FIFO write port, and stalls on `full` without dropping words. It sits directly in front of the FIFO write side; the read side is unaffected.

## Interface
- `NUM_REQ`, 4, number of producers (2..8)
- `WIDTH`, 8, data word width; matches FIFO `WIDTH`
- `BURST_MAX`, 4, maximum accepted words per grant (1..15)
- `clk`  in  1  write-domain clock; connects with FIFO `wr_clk`
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  NUM_REQ  per-producer request, level, held while data pending
- `wdata_in`  in  NUM_REQ*WIDTH  producer data; producer i drives slice [i*WIDTH +: WIDTH]
- `full`  in  1  FIFO full flag
- `gnt`  out  NUM_REQ  registered one-hot grant (all-zero when idle)
- `ack`  out  NUM_REQ  combinational; ack[i] = gnt[i] & req[i] & ~full, word accepted this edge
- `wr_en`  out  1  FIFO write enable = |ack
- `wdata`  out  WIDTH  FIFO write data = owner's slice; 0 when no grant
- `stall_cnt`  out  16  full-stall cycle counter (see Configuration)

## Operation
- States: IDLE (gnt=0), GRANT (one owner). State, `gnt`, `last` (last owner index), `burst` (4-bit accepted-word count) are registers.
- Arbitration: candidate search starts at index (last+1) mod NUM_REQ, wraps, first set `req` bit wins.
- IDLE: any `req` set -> GRANT to winner at next edge, `burst`=0. No req -> stay IDLE.
- GRANT, per edge:
  - ack of owner -> `burst`+1.
  - Release when owner's `req`=0, or ack with `burst`=BURST_MAX-1 (burst completes).
  - On release, re-arbitrate on same edge excluding nothing: search starts after current owner, so current owner re-wins only if no other requester; `last`=owner; `burst`=0. No requester -> IDLE.
  - `full`=1: no ack, `burst` holds, grant held (full never forces release).
- Producer contract: keeps `req` and data stable until ack; advances to next word the cycle after ack; drops `req` after final ack.
- `wdata` is a pure mux of the owner slice; `wr_en` never asserts while `full`=1.
- Reset (any time, including mid-burst): state IDLE, `gnt`=0, `burst`=0, `last`=NUM_REQ-1 (producer 0 has first priority), `stall_cnt`=0. Outputs `ack`, `wr_en`, `wdata` read 0 during reset.

## Timing
- Request-to-grant: 1 clk from IDLE (req seen at edge n, gnt valid after edge n, first ack possible in cycle n+1).
- Owner handover: 0 dead cycles; new owner's gnt valid in the cycle following the releasing edge.
- Throughput: one word per clk while owner requests and `full`=0.
- `ack`/`wr_en`/`wdata` combinational from registered `gnt`, live `req`, `full`; `full` to `wr_en` is the only same-cycle path from the FIFO.
- Fairness: any continuously requesting producer is granted within NUM_REQ-1 grants of others.

## Configuration
- `FIFO_WR_ARB_STATS_EN` defined: `stall_cnt` increments each clk where a grant exists, owner `req`=1 and `full`=1; saturates at 16'hFFFF; cleared only by `rst`.
- Undefined: counter logic not compiled; `stall_cnt` tied to 16'h0000.

## Test plan
- Reset, req=4'b0001, 6 words 0x11..0x16, full=0 -> gnt=0001 one clk later; 4 acks (burst), one release edge re-granting 0 with 0 dead cycles, remaining 2 words; FIFO receives 0x11..0x16 in order.
- req=4'b1111 all continuous, BURST_MAX=4 -> grant order 0,1,2,3,0; exactly 4 wr_en per grant, no idle cycle between owners.
- Owner 2 granted, full forced 1 for 5 clks mid-burst -> wr_en=0, gnt held, burst unchanged; with macro stall_cnt=5, without stall_cnt=0; writes resume with the stalled word.
- Owner 1 drops req after 2 acks with req[3]=1 -> next edge gnt=1000, last=1; with req=0 everywhere -> IDLE, gnt=0000, wdata=0.
- Assert rst mid-burst (owner 3, burst=2) -> gnt=0, wr_en=0 immediately; after release with req=4'b1001 -> producer 0 granted first.
